// File: rtl/crossbar_ingress_scheduler.sv
// Ingress stage in front of the crossbar: one FIFO per input plus per-destination
// round-robin arbitration, so each output port sees at most one requester per cycle.
module crossbar_ingress_scheduler #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int DW    = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_dest,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    req,
    output logic [N*DW-1:0] dest,
    output logic [N*W-1:0]  data,
    output logic [15:0]     drop_count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int NCW = $clog2(N + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [DW:0]   M_LIM    = (DW + 1)'(M);

    logic [DW-1:0]  fifo_dest_r [N][DEPTH];
    logic [W-1:0]   fifo_data_r [N][DEPTH];
    logic [PW-1:0]  wr_ptr_r [N];
    logic [PW-1:0]  rd_ptr_r [N];
    logic [CW-1:0]  count_r  [N];
    logic [IW-1:0]  rr_ptr_r [M];
    logic [IW-1:0]  rr_next_s [M];

    logic [N-1:0]    req_r;
    logic [N*DW-1:0] dest_r;
    logic [N*W-1:0]  data_r;
    logic [15:0]     drop_count_r;

    logic [N-1:0]   head_valid_s;
    logic [N-1:0]   bad_s;
    logic [N-1:0]   grant_s;
    logic [N-1:0]   push_s;
    logic [N-1:0]   pop_s;
    logic [DW-1:0]  head_dest_s [N];
    logic [W-1:0]   head_data_s [N];
    logic [NCW-1:0] drop_inc_s;
    logic [16:0]    drop_sum_s;
    logic [IW-1:0]  idx_s;
    logic           found_s;
    logic           hit_s;

    // FIFO head decode, ready/push qualification and dropped-beat tally
    always_comb begin
        drop_inc_s = {NCW{1'b0}};
        for (int i = 0; i < N; i++) begin
            head_valid_s[i] = (count_r[i] != {CW{1'b0}});
            head_dest_s[i]  = fifo_dest_r[i][rd_ptr_r[i]];
            head_data_s[i]  = fifo_data_r[i][rd_ptr_r[i]];
            bad_s[i]        = head_valid_s[i] && ({1'b0, head_dest_s[i]} >= M_LIM);
            in_ready[i]     = !rst && (count_r[i] != FULL_CNT);
            push_s[i]       = in_valid[i] && in_ready[i];
            drop_inc_s      = drop_inc_s + NCW'(bad_s[i]);
        end
        drop_sum_s = {1'b0, drop_count_r} + 17'(drop_inc_s);
        pop_s      = grant_s | bad_s;
    end

    // Per-destination round-robin scan starting at rr_ptr
    always_comb begin
        grant_s = {N{1'b0}};
        idx_s   = {IW{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int d = 0; d < M; d++) begin
            rr_next_s[d] = rr_ptr_r[d];
            found_s      = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx_s = IW'((int'(rr_ptr_r[d]) + k) % N);
                hit_s = !found_s && head_valid_s[idx_s] && !bad_s[idx_s] &&
                        (head_dest_s[idx_s] == DW'(d));
                if (hit_s) begin
                    grant_s[idx_s] = 1'b1;
                    rr_next_s[d]   = IW'((int'(idx_s) + 1) % N);
                end else begin
                    rr_next_s[d]   = rr_next_s[d];
                end
                found_s = found_s | hit_s;
            end
        end
    end

    // FIFO storage writes; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_s[i]) begin
                fifo_dest_r[i][wr_ptr_r[i]] <= in_dest[i*DW +: DW];
                fifo_data_r[i][wr_ptr_r[i]] <= in_data[i*W +: W];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_r[i] <= {PW{1'b0}};
                rd_ptr_r[i] <= {PW{1'b0}};
                count_r[i]  <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1'b1);
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1'b1);
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CW'(1'b1);
                    2'b01:   count_r[i] <= count_r[i] - CW'(1'b1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Arbiter pointers, registered crossbar request and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < M; d++) rr_ptr_r[d] <= {IW{1'b0}};
            req_r        <= {N{1'b0}};
            dest_r       <= {(N*DW){1'b0}};
            data_r       <= {(N*W){1'b0}};
            drop_count_r <= 16'h0000;
        end else begin
            for (int d = 0; d < M; d++) rr_ptr_r[d] <= rr_next_s[d];
            req_r <= grant_s;
            for (int i = 0; i < N; i++) begin
                if (grant_s[i]) begin
                    dest_r[i*DW +: DW] <= head_dest_s[i];
                    data_r[i*W +: W]   <= head_data_s[i];
                end
            end
            if (drop_sum_s > 17'h0FFFF) drop_count_r <= 16'hFFFF;
            else                        drop_count_r <= drop_sum_s[15:0];
        end
    end

    assign req        = req_r;
    assign dest       = dest_r;
    assign data       = data_r;
    assign drop_count = drop_count_r;

endmodule

// Output-side invariant: two simultaneous requests never share a destination.
module crossbar_ingress_scheduler_checker #(
    parameter int N  = 4,
    parameter int DW = 2
) (
    input logic            clk,
    input logic            rst,
    input logic [N-1:0]    req,
    input logic [N*DW-1:0] dest
);
    for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = i + 1; j < N; j++) begin : g_j
            a_unique_dest: assert property (@(posedge clk) disable iff (rst)
                !(req[i] && req[j]) || (dest[i*DW +: DW] != dest[j*DW +: DW]));
        end
    end
endmodule

// File: tb/tb_crossbar_ingress_scheduler.sv
// Directed bench: instance a uses M=4, instance b uses M=3 to exercise invalid destinations.
module tb_crossbar_ingress_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   a_in_valid, a_in_ready, a_req;
    logic [7:0]   a_in_dest, a_dest;
    logic [127:0] a_in_data, a_data;
    logic [15:0]  a_drop_count;
    logic [3:0]   b_in_valid, b_in_ready, b_req;
    logic [7:0]   b_in_dest, b_dest;
    logic [127:0] b_in_data, b_data;
    logic [15:0]  b_drop_count;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    crossbar_ingress_scheduler #(.N(4), .M(4), .W(32), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_dest(a_in_dest), .in_data(a_in_data),
        .in_ready(a_in_ready), .req(a_req), .dest(a_dest), .data(a_data), .drop_count(a_drop_count));

    crossbar_ingress_scheduler #(.N(4), .M(3), .W(32), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_dest(b_in_dest), .in_data(b_in_data),
        .in_ready(b_in_ready), .req(b_req), .dest(b_dest), .data(b_data), .drop_count(b_drop_count));

    crossbar_ingress_scheduler_checker #(.N(4), .DW(2)) chk_a (.clk(clk), .rst(rst), .req(a_req), .dest(a_dest));
    crossbar_ingress_scheduler_checker #(.N(4), .DW(2)) chk_b (.clk(clk), .rst(rst), .req(b_req), .dest(b_dest));

    task automatic idle_inputs();
        a_in_valid = 4'h0; a_in_dest = 8'h00; a_in_data = 128'h0;
        b_in_valid = 4'h0; b_in_dest = 8'h00; b_in_data = 128'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 4'h0 || b_in_ready !== 4'h0) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b, want 0000", a_in_ready, b_in_ready);
        end
        n_cmp++;
        if (a_req !== 4'h0 || a_drop_count !== 16'h0 || b_drop_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_outputs: req=%b drop=%h/%h, want 0", a_req, a_drop_count, b_drop_count);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 4'hF) begin
            n_fail++; $display("FAIL reset_release_ready: got %b, want 1111", a_in_ready);
        end
        n_cmp++;
        if (a_dest !== 8'h00 || a_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_dest_data: dest=%h data=%h, want 0", a_dest, a_data);
        end
    endtask

    task automatic test_reset_mid_traffic();
        int stale;
        stale = 0;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 4'b0011;
            a_in_dest  = 8'h00;
            a_in_data[31:0]  = 32'hB000_0000 | k;
            a_in_data[63:32] = 32'hB100_0000 | k;
            @(negedge clk);
        end
        a_in_valid = 4'h0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_req !== 4'h0 || a_in_ready !== 4'h0) begin
            n_fail++; $display("FAIL midreset_during: req=%b ready=%b, want 0000/0000", a_req, a_in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_req !== 4'h0) stale++;
        end
        n_cmp++;
        if (stale !== 0) begin
            n_fail++; $display("FAIL midreset_stale: %0d req cycles after reset, want 0", stale);
        end
        n_cmp++;
        if (a_in_ready !== 4'hF) begin
            n_fail++; $display("FAIL midreset_ready: got %b, want 1111", a_in_ready);
        end
    endtask

    task automatic test_single();
        a_in_valid = 4'b0100;
        a_in_dest  = 8'b00_01_00_00;
        a_in_data  = 128'h0;
        a_in_data[95:64] = 32'hA5A5_0001;
        @(negedge clk);
        n_cmp++;
        if (a_req !== 4'h0) begin
            n_fail++; $display("FAIL single_no_bypass: req=%b, want 0000", a_req);
        end
        a_in_valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (a_req !== 4'b0100 || a_dest[5:4] !== 2'd1 || a_data[95:64] !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL single_req: req=%b dest=%0d data=%h, want 0100/1/a5a50001",
                               a_req, a_dest[5:4], a_data[95:64]);
        end
        @(negedge clk);
        n_cmp++;
        if (a_req !== 4'h0 || a_dest[5:4] !== 2'd1 || a_data[95:64] !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL single_one_cycle: req=%b dest=%0d data=%h, want 0000/1/a5a50001",
                               a_req, a_dest[5:4], a_data[95:64]);
        end
    endtask

    task automatic test_full_contention();
        int sent[4];
        int exp_k[4];
        int turn;
        int pulses;
        logic [3:0]  fire;
        logic [31:0] exp_data;
        turn = 0; pulses = 0;
        for (int i = 0; i < 4; i++) begin sent[i] = 0; exp_k[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 4; i++) begin
                a_in_valid[i]       = (sent[i] < 4);
                a_in_dest[i*2 +: 2] = 2'd3;
                a_in_data[i*32 +: 32] = 32'hC000_0000 | (i << 8) | sent[i];
            end
            fire = a_in_valid & a_in_ready;
            for (int i = 0; i < 4; i++) if (fire[i]) sent[i]++;
            @(negedge clk);
            if (a_req !== 4'h0) begin
                n_cmp++;
                if (a_req !== (4'b0001 << turn)) begin
                    n_fail++; $display("FAIL contention_order: req=%b, want %b", a_req, 4'b0001 << turn);
                end
                exp_data = 32'hC000_0000 | (turn << 8) | exp_k[turn];
                n_cmp++;
                if (a_dest[turn*2 +: 2] !== 2'd3 || a_data[turn*32 +: 32] !== exp_data) begin
                    n_fail++; $display("FAIL contention_payload: in%0d dest=%0d data=%h, want 3/%h",
                                       turn, a_dest[turn*2 +: 2], a_data[turn*32 +: 32], exp_data);
                end
                exp_k[turn]++;
                turn = (turn + 1) % 4;
                pulses++;
            end
        end
        a_in_valid = 4'h0;
        n_cmp++;
        if (pulses !== 16) begin
            n_fail++; $display("FAIL contention_count: %0d pulses, want 16", pulses);
        end
    endtask

    task automatic test_parallel();
        logic [3:0]  exp_req;
        logic [31:0] exp_data;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 4; i++) begin
                a_in_valid[i]         = (c < 8);
                a_in_dest[i*2 +: 2]   = 2'((i + 1) % 4);
                a_in_data[i*32 +: 32] = 32'hD000_0000 | (i << 8) | c;
            end
            if (c < 8) begin
                n_cmp++;
                if (a_in_ready !== 4'hF) begin
                    n_fail++; $display("FAIL parallel_ready: cycle %0d ready=%b, want 1111", c, a_in_ready);
                end
            end
            @(negedge clk);
            exp_req = (c >= 1 && c <= 8) ? 4'hF : 4'h0;
            n_cmp++;
            if (a_req !== exp_req) begin
                n_fail++; $display("FAIL parallel_req: cycle %0d req=%b, want %b", c, a_req, exp_req);
            end
            if (exp_req == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    exp_data = 32'hD000_0000 | (i << 8) | (c - 1);
                    n_cmp++;
                    if (a_dest[i*2 +: 2] !== 2'((i + 1) % 4) || a_data[i*32 +: 32] !== exp_data) begin
                        n_fail++; $display("FAIL parallel_payload: in%0d dest=%0d data=%h, want %0d/%h",
                                           i, a_dest[i*2 +: 2], a_data[i*32 +: 32], (i + 1) % 4, exp_data);
                    end
                end
            end
        end
        a_in_valid = 4'h0;
    endtask

    task automatic test_fifo_full();
        int total[2];
        int sent[2];
        int got[2];
        int seen_full;
        logic [3:0]  fire;
        logic [31:0] exp_data;
        total[0] = 10; total[1] = 8;
        sent[0] = 0; sent[1] = 0; got[0] = 0; got[1] = 0; seen_full = 0;
        a_in_dest = 8'h00;
        for (int c = 0; c < 40; c++) begin
            a_in_valid = 4'h0;
            for (int i = 0; i < 2; i++) begin
                a_in_valid[i] = (sent[i] < total[i]);
                a_in_data[i*32 +: 32] = 32'hE000_0000 | (i << 24) | sent[i];
            end
            fire = a_in_valid & a_in_ready;
            for (int i = 0; i < 2; i++) if (fire[i]) sent[i]++;
            @(negedge clk);
            n_cmp++;
            if ((a_req[0] && a_req[1]) || a_req[3:2] !== 2'b00) begin
                n_fail++; $display("FAIL fifo_full_exclusive: req=%b", a_req);
            end
            for (int i = 0; i < 2; i++) begin
                if (a_req[i]) begin
                    exp_data = 32'hE000_0000 | (i << 24) | got[i];
                    n_cmp++;
                    if (a_data[i*32 +: 32] !== exp_data) begin
                        n_fail++; $display("FAIL fifo_full_order: in%0d data=%h, want %h", i, a_data[i*32 +: 32], exp_data);
                    end
                    got[i]++;
                end
            end
            n_cmp++;
            if (a_in_ready[1] !== ((sent[1] - got[1]) != 4)) begin
                n_fail++; $display("FAIL fifo_full_ready: ready1=%b with %0d held, want %b",
                                   a_in_ready[1], sent[1] - got[1], (sent[1] - got[1]) != 4);
            end
            if (a_in_ready[1] === 1'b0) seen_full = 1;
        end
        a_in_valid = 4'h0;
        n_cmp++;
        if (got[0] !== 10 || got[1] !== 8) begin
            n_fail++; $display("FAIL fifo_full_count: got %0d/%0d beats, want 10/8", got[0], got[1]);
        end
        n_cmp++;
        if (seen_full !== 1) begin
            n_fail++; $display("FAIL fifo_full_seen: in_ready[1] never dropped, want a drop");
        end
    endtask

    task automatic test_invalid_dest();
        int pulses;
        pulses = 0;
        b_in_valid = 4'b0001;
        b_in_dest  = 8'b00_00_00_11;
        b_in_data  = 128'h0;
        b_in_data[31:0] = 32'hBAD0_0001;
        @(negedge clk);
        b_in_valid = 4'h0;
        n_cmp++;
        if (b_drop_count !== 16'h0000) begin
            n_fail++; $display("FAIL invalid_early: drop=%h, want 0000", b_drop_count);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (b_req !== 4'h0) pulses++;
        end
        n_cmp++;
        if (b_drop_count !== 16'h0001 || pulses !== 0) begin
            n_fail++; $display("FAIL invalid_drop: drop=%h req_cycles=%0d, want 0001/0", b_drop_count, pulses);
        end
    endtask

    task automatic test_drop_saturation();
        int target;
        int sent;
        int rem;
        int cycles;
        int pulses;
        logic [3:0] fire;
        target = 65533; sent = 0; cycles = 0; pulses = 0;
        b_in_dest = 8'hFF;
        while (sent < target && cycles < 20000) begin
            rem = target - sent;
            b_in_valid = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            b_in_data  = {4{32'(cycles)}};
            fire = b_in_valid & b_in_ready;
            sent += $countones(fire);
            @(negedge clk);
            if (b_req !== 4'h0) pulses++;
            cycles++;
        end
        b_in_valid = 4'h0;
        n_cmp++;
        if (sent !== target) begin
            n_fail++; $display("FAIL drop_timeout: sent %0d bad beats, want %0d", sent, target);
        end
        repeat (3) begin
            @(negedge clk);
            if (b_req !== 4'h0) pulses++;
        end
        n_cmp++;
        if (b_drop_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL drop_fffe: drop=%h, want fffe", b_drop_count);
        end
        sent = 0; cycles = 0;
        while (sent < 3 && cycles < 50) begin
            b_in_valid = 4'b0001;
            fire = b_in_valid & b_in_ready;
            sent += $countones(fire);
            @(negedge clk);
            if (b_req !== 4'h0) pulses++;
            cycles++;
        end
        b_in_valid = 4'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b_drop_count !== 16'hFFFF || sent !== 3) begin
            n_fail++; $display("FAIL drop_saturate: drop=%h sent=%0d, want ffff/3", b_drop_count, sent);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL drop_no_req: %0d req cycles on bad beats, want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_traffic();
        test_single();
        repeat (2) @(negedge clk);
        test_full_contention();
        repeat (2) @(negedge clk);
        test_parallel();
        repeat (2) @(negedge clk);
        test_fifo_full();
        repeat (2) @(negedge clk);
        test_invalid_dest();
        test_drop_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
